// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 frame scheduler: state encoding,
// pixel word width and LED latch timing.
package ws2812_pkg;

  // One GRB pixel word, MSB (green bit 7) shifted out first.
  localparam int GRB_W = 24;

  // Low time the LED chain needs before it latches a frame.
  localparam int LATCH_US = 60;

  // Width of a requester's pixel-index field.
  localparam int IDX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } sched_state_e;

  // Converts the latch time into clock cycles for a given clock frequency.
  function automatic int latch_cycles(input int clk_hz);
    return clk_hz / 1_000_000 * LATCH_US;
  endfunction

endpackage

// File: rtl/ws2812_rr_arb.sv
// Round-robin arbiter: one-hot combinational grant, with a registered
// pointer that moves to one past the requester that was granted.
module ws2812_rr_arb
  import ws2812_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;
  logic          found;
  int            cand;

  // Scan requesters starting at the pointer; the first active one wins.
  always_comb begin
    grant    = '0;
    ptr_next = ptr_reg;
    found    = 1'b0;
    cand     = 0;
    if (enable) begin
      for (int i = 0; i < N; i++) begin
        cand = int'(ptr_reg) + i;
        if (cand >= N) begin
          cand = cand - N;
        end
        if (!found && req[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          ptr_next    = (cand == N - 1) ? '0 : PW'(cand + 1);
        end
      end
    end
  end

  // Pointer register; requester 0 has first priority out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/ws2812_sched.sv
// WS2812 frame scheduler: arbitrates pixel writes from several requesters
// into a register file and streams the whole chain to a bit serializer
// whenever the contents changed (or a frame is forced), honouring a
// minimum refresh spacing and the latch gap between frames.
module ws2812_sched
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS    = 8,
  parameter int NUM_REQ     = 2,
  parameter int CLK_FRE     = 27_000_000,
  parameter int RESET_CYC   = latch_cycles(CLK_FRE),
  parameter int REFRESH_CYC = CLK_FRE / 100
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  input  logic [NUM_REQ*GRB_W-1:0] req_color,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     force_req,
  output logic                     pix_valid,
  output logic [GRB_W-1:0]         pix_data,
  output logic                     pix_last,
  input  logic                     pix_ready,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam int GW = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

  localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_LEDS - 1);
  localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_CYC - 1);
  localparam logic [GW-1:0] GAP_MAX     = GW'(RESET_CYC - 1);

  // ---------------------------------------------------------------
  // Write arbitration
  // ---------------------------------------------------------------
  logic [NUM_REQ-1:0] grant;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [GRB_W-1:0]   wr_color;
  logic               wr_in_range;

  ws2812_rr_arb #(
    .N(NUM_REQ)
  ) u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    (req_valid),
    .enable (1'b1),
    .grant  (grant)
  );

  // Every request is accepted, including out-of-range ones, which are dropped.
  assign req_ready = grant;

  // Select the granted requester's index and color.
  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_color = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        wr_en    = 1'b1;
        wr_idx   = req_idx[IDX_W*k +: IDX_W];
        wr_color = req_color[GRB_W*k +: GRB_W];
      end
    end
  end

  assign wr_in_range = wr_en && (int'(wr_idx) < NUM_LEDS);

  // ---------------------------------------------------------------
  // Pixel register file (cleared by reset, so built from flops)
  // ---------------------------------------------------------------
  logic [GRB_W-1:0] mem_reg [NUM_LEDS];

  generate
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_pix
      // One pixel entry, written when the granted index selects it.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          mem_reg[gi] <= '0;
        end else if (wr_in_range && (int'(wr_idx) == gi)) begin
          mem_reg[gi] <= wr_color;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------
  // Frame scheduler FSM
  // ---------------------------------------------------------------
  sched_state_e     state_reg,       state_next;
  logic             dirty_reg,       dirty_next;
  logic             force_pend_reg,  force_pend_next;
  logic [RW-1:0]    refresh_cnt_reg, refresh_cnt_next;
  logic [GW-1:0]    gap_cnt_reg,     gap_cnt_next;
  logic [IW-1:0]    pix_idx_reg,     pix_idx_next;
  logic             pix_valid_reg,   pix_valid_next;
  logic             pix_last_reg,    pix_last_next;
  logic [GRB_W-1:0] pix_data_reg,    pix_data_next;
  logic             frame_done_reg,  frame_done_next;

  logic             xfer;
  logic             refresh_at_max;
  logic [IW-1:0]    nxt_idx;

  assign xfer           = pix_valid_reg & pix_ready;
  assign refresh_at_max = (refresh_cnt_reg == REFRESH_MAX);
  assign nxt_idx        = (pix_idx_reg == LAST_IDX) ? '0 : pix_idx_reg + 1'b1;

  // Next-state and datapath: start frames, stream pixels, time the latch gap.
  always_comb begin
    state_next       = state_reg;
    dirty_next       = dirty_reg | wr_in_range;
    force_pend_next  = force_pend_reg | force_req;
    refresh_cnt_next = refresh_at_max ? refresh_cnt_reg : refresh_cnt_reg + 1'b1;
    gap_cnt_next     = gap_cnt_reg;
    pix_idx_next     = pix_idx_reg;
    pix_valid_next   = pix_valid_reg;
    pix_last_next    = pix_last_reg;
    pix_data_next    = pix_data_reg;
    frame_done_next  = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if ((dirty_reg || force_pend_reg) && refresh_at_max) begin
          state_next       = ST_STREAM;
          // A write landing on the start cycle is not in this frame, so it
          // re-arms dirty for the next one.
          dirty_next       = wr_in_range;
          force_pend_next  = force_req;
          refresh_cnt_next = '0;
          pix_idx_next     = '0;
          pix_data_next    = mem_reg[0];
          pix_valid_next   = 1'b1;
          pix_last_next    = (NUM_LEDS == 1);
        end
      end

      ST_STREAM: begin
        // Output word is only replaced on a transfer, so a stalled word
        // stays stable even if its entry is rewritten meanwhile.
        if (xfer) begin
          if (pix_last_reg) begin
            state_next     = ST_GAP;
            pix_valid_next = 1'b0;
            pix_last_next  = 1'b0;
            gap_cnt_next   = '0;
          end else begin
            pix_idx_next  = nxt_idx;
            pix_data_next = mem_reg[nxt_idx];
            pix_last_next = (nxt_idx == LAST_IDX);
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_reg == GAP_MAX) begin
          state_next      = ST_IDLE;
          frame_done_next = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; refresh counter starts saturated so the
  // first change after reset goes out immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= ST_IDLE;
      dirty_reg       <= 1'b0;
      force_pend_reg  <= 1'b0;
      refresh_cnt_reg <= REFRESH_MAX;
      gap_cnt_reg     <= '0;
      pix_idx_reg     <= '0;
      pix_valid_reg   <= 1'b0;
      pix_last_reg    <= 1'b0;
      pix_data_reg    <= '0;
      frame_done_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      dirty_reg       <= dirty_next;
      force_pend_reg  <= force_pend_next;
      refresh_cnt_reg <= refresh_cnt_next;
      gap_cnt_reg     <= gap_cnt_next;
      pix_idx_reg     <= pix_idx_next;
      pix_valid_reg   <= pix_valid_next;
      pix_last_reg    <= pix_last_next;
      pix_data_reg    <= pix_data_next;
      frame_done_reg  <= frame_done_next;
    end
  end

  assign pix_valid  = pix_valid_reg;
  assign pix_data   = pix_data_reg;
  assign pix_last   = pix_last_reg;
  assign frame_done = frame_done_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: doc/ws2812_sched.md
WS2812_SCHED -- requirements
Module: ws2812_sched

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, number of pixels in the chain (1..256).
REQ-002 SHALL have parameter NUM_REQ, default 2, number of color-write requesters (1..8).
REQ-003 SHALL have parameter CLK_FRE, default 27_000_000, clock frequency in Hz.
REQ-004 SHALL have parameter RESET_CYC, default CLK_FRE/1_000_000*60, latch gap in cycles (60 us).
REQ-005 SHALL have parameter REFRESH_CYC, default CLK_FRE/100, minimum frame-start spacing in cycles (10 ms).
REQ-006 SHALL have one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-009 SHALL have port req_valid  input  NUM_REQ  per-requester write request.
REQ-010 SHALL have port req_idx  input  NUM_REQ*8  per-requester pixel index, requester k at bits [8k+7:8k].
REQ-011 SHALL have port req_color  input  NUM_REQ*24  per-requester GRB color, requester k at bits [24k+23:24k].
REQ-012 SHALL have port req_ready  output  NUM_REQ  one-hot grant, combinational, write accepted this cycle.
REQ-013 SHALL have port force  input  1  single-cycle pulse requesting a frame regardless of the dirty flag.
REQ-014 SHALL have port pix_valid  output  1  pixel word offered to the bit serializer.
REQ-015 SHALL have port pix_data  output  24  GRB word, MSB sent first by the serializer.
REQ-016 SHALL have port pix_last  output  1  marks the final pixel of the frame.
REQ-017 SHALL have port pix_ready  input  1  serializer accepts the word (transfer = pix_valid & pix_ready).
REQ-018 SHALL have port busy  output  1  high in STREAM and GAP.
REQ-019 SHALL have port frame_done  output  1  one-cycle pulse when GAP completes.

Function
REQ-020 SHALL hold a NUM_LEDS x 24 pixel register file; all entries 0 after reset.
REQ-021 SHALL grant at most one requester per cycle, round-robin, with the pointer advancing to one past the granted requester.
REQ-022 SHALL write req_color into entry req_idx on the grant cycle, visible to reads on the next cycle.
REQ-023 SHALL grant and discard writes with req_idx >= NUM_LEDS, without setting dirty.
REQ-024 SHALL set dirty on every in-range write, including writes during STREAM or GAP.
REQ-025 SHALL latch a force pulse into force_pend, cleared on frame start.
REQ-026 SHALL implement states IDLE, STREAM, GAP.
REQ-027 SHALL leave IDLE for STREAM when (dirty or force_pend) and refresh_cnt has reached REFRESH_CYC-1, clearing dirty and force_pend and resetting refresh_cnt in the same cycle.
REQ-028 SHALL keep dirty set when a write coincides with the frame-start cycle (the write wins).
REQ-029 SHALL saturate refresh_cnt at REFRESH_CYC-1 and restart it from 0 on each frame start.
REQ-030 SHALL, in STREAM, register pix_data from entry pix_idx, starting at index 0, with pix_valid asserted the cycle after entry.
REQ-031 SHALL hold pix_data, pix_last and pix_valid stable while pix_valid & !pix_ready, even if that entry is rewritten.
REQ-032 SHALL, on each transfer, load the next index (no bubble) or, if pix_last, drop pix_valid and enter GAP.
REQ-033 SHALL assert pix_last exactly when pix_idx == NUM_LEDS-1.
REQ-034 SHALL stay in GAP for RESET_CYC cycles, then pulse frame_done and return to IDLE.
REQ-035 SHALL ignore force and dirty while in STREAM or GAP, except for latching them for the next frame.

Reset
REQ-036 SHALL, on resetn low, immediately clear state to IDLE, pix_valid, pix_last, pix_data, busy, frame_done, dirty, force_pend, counters and the arbiter pointer (requester 0 first), even mid-frame.
REQ-037 SHALL preload refresh_cnt to REFRESH_CYC-1 so the first dirty write starts a frame without waiting.

Structure
REQ-038 SHALL place the state encoding, the 24-bit GRB width and the 60 us latch-time constant in shared package ws2812_pkg.
REQ-039 SHALL implement the round-robin arbiter as sub-module ws2812_rr_arb (inputs req/enable, output one-hot grant, registered pointer).

Verification
REQ-040 SHALL cover: requester 0 writes idx 3 = 0x00FF00 with pix_ready tied 1 -> 8 transfers, word 3 = 0x00FF00, others 0, pix_last on 8th, frame_done 1620 cycles later.
REQ-041 SHALL cover: both requesters valid for 4 cycles -> grants alternate 0,1,0,1.
REQ-042 SHALL cover: pix_ready low 10 cycles on pixel 2 while idx 2 is rewritten -> pix_data unchanged until accepted, and a second frame follows.
REQ-043 SHALL cover: a write to idx 200 -> req_ready=1, no frame starts; then force -> a frame starts with all words 0.
REQ-044 SHALL cover: a second write 5 cycles after frame start, with REFRESH_CYC=1000 -> the next frame starts 1000 cycles after the first.
REQ-045 SHALL cover: resetn low during pixel 4 of STREAM -> pix_valid=0, busy=0 at once, IDLE after release, register file cleared.
